// File: rtl/full_adder_implicit.sv
// Registered WIDTH-bit implicit full adder: {co, s} = a + b + ci with valid tracking.
// Define FULL_ADDER_IMPLICIT_OVF_EN to add the signed-overflow output ovf.
module full_adder_implicit #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             out_valid
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshake: in_valid qualifies a/b/ci for one cycle; out_valid marks s/co
  // as a fresh result for exactly one cycle. There is no ready: every result
  // must be taken by the consumer.

  // Operands are widened before the add so the carry lands in bit WIDTH.
  logic [WIDTH:0] full;
  logic           ovf_c;

  assign full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] s_q;
      logic             co_q;
      logic             valid_q;
      logic             ovf_q;

      // Result registers load only on a valid beat so idle inputs never disturb them.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q     <= '0;
          co_q    <= 1'b0;
          ovf_q   <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= in_valid;
          if (in_valid) begin
            s_q   <= full[WIDTH-1:0];
            co_q  <= full[WIDTH];
            ovf_q <= ovf_c;
          end
        end
      end

      assign s         = s_q;
      assign co        = co_q;
      assign out_valid = valid_q;
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
      assign ovf       = ovf_q;
`else
      logic unused_ovf;
      assign unused_ovf = ovf_q;
`endif
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign s         = full[WIDTH-1:0];
      assign co        = full[WIDTH];
      assign out_valid = in_valid;
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
      assign ovf       = ovf_c;
`else
      logic unused_ovf;
      assign unused_ovf = ovf_c;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_implicit.sv
// Bench for full_adder_implicit: registered 1-bit and 8-bit instances checked by
// queue-based monitors, plus a 4-bit combinational instance checked directly.
module tb_full_adder_implicit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #100 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 1-bit registered instance
  logic iv1 = 1'b0, ci1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic co1, ov1;
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
  logic ovf1;
`endif

  full_adder_implicit #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .ci(ci1), .a(a1), .b(b1),
    .s(s1), .co(co1), .out_valid(ov1)
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
    , .ovf(ovf1)
`endif
  );

  // 8-bit registered instance
  logic iv8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic co8, ov8;
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
  logic ovf8;
`endif

  full_adder_implicit #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .ci(ci8), .a(a8), .b(b8),
    .s(s8), .co(co8), .out_valid(ov8)
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
    , .ovf(ovf8)
`endif
  );

  // 4-bit combinational instance
  logic ivc = 1'b0, cic = 1'b0;
  logic [3:0] ac = '0, bc = '0, sc;
  logic coc, ovc;
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
  logic ovfc;
`endif

  full_adder_implicit #(.WIDTH(4), .REG_OUT(1'b0)) uc (
    .clk(clk), .rst_n(rst_n), .in_valid(ivc), .ci(cic), .a(ac), .b(bc),
    .s(sc), .co(coc), .out_valid(ovc)
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
    , .ovf(ovfc)
`endif
  );

  logic [1:0] exp1_q[$];   // {co, s}
  logic [9:0] exp8_q[$];   // {ovf, co, s}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drivers: apply just after a rising edge, push expectation for valid beats.
  task automatic drive1(input logic iv, input logic c, input logic a, input logic b,
                        input logic es, input logic eco);
    @(posedge clk);
    #1;
    iv1 = iv; ci1 = c; a1 = a; b1 = b;
    if (iv) exp1_q.push_back({eco, es});
  endtask

  task automatic drive8(input logic iv, input logic c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic eco, input logic eovf);
    @(posedge clk);
    #1;
    iv8 = iv; ci8 = c; a8 = a; b8 = b;
    if (iv) exp8_q.push_back({eovf, eco, es});
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rst_n && ov1) begin
      if (exp1_q.size() == 0) check("u1_unexpected_valid", 64'(ov1), 64'(0));
      else check("u1_result", 64'({co1, s1}), 64'(exp1_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (exp8_q.size() == 0) check("u8_unexpected_valid", 64'(ov8), 64'(0));
      else begin
        logic [9:0] e;
        e = exp8_q.pop_front();
`ifdef FULL_ADDER_IMPLICIT_OVF_EN
        check("u8_result", 64'({ovf8, co8, s8}), 64'(e));
`else
        check("u8_result", 64'({co8, s8}), 64'(e[8:0]));
`endif
      end
    end
  end

  task automatic check_comb(input logic iv, input logic c, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] es, input logic eco);
    ivc = iv; cic = c; ac = a; bc = b;
    #1;
    check("comb_sum", 64'({coc, sc}), 64'({eco, es}));
    check("comb_valid", 64'(ovc), 64'(iv));
  endtask

  initial begin
    #50;
    check("reset_u1", 64'({ov1, co1, s1}), 64'(0));
    check("reset_u8", 64'({ov8, co8, s8}), 64'(0));
    #200;
    rst_n = 1'b1;

    // Truth table, back-to-back (ci,a,b)
    drive1(1, 0, 0, 0, 0, 0);
    drive1(1, 0, 1, 0, 1, 0);
    drive1(1, 0, 1, 1, 0, 1);
    drive1(1, 0, 0, 1, 1, 0);
    drive1(1, 1, 0, 1, 0, 1);
    drive1(1, 1, 1, 1, 1, 1);
    drive1(1, 1, 1, 0, 0, 1);
    drive1(1, 1, 0, 0, 1, 0);
    drive1(0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    check("idle_valid_low", 64'(ov1), 64'(0));

    // Hold: result stays while in_valid is low, even with new or unknown inputs
    drive1(1, 0, 1, 0, 1, 0);
    drive1(0, 1, 1, 1, 0, 0);
    @(posedge clk); @(negedge clk);
    check("hold_result", 64'({co1, s1}), 64'(2'b01));
    check("hold_valid", 64'(ov1), 64'(0));
    a1 = 1'bx; b1 = 1'bx;
    @(posedge clk); @(negedge clk);
    check("hold_x_inputs", 64'({ov1, co1, s1}), 64'(3'b001));

    // Asynchronous reset between edges
    drive1(1, 1, 1, 1, 1, 1);
    drive1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #20;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({ov1, co1, s1}), 64'(0));
    #20;
    rst_n = 1'b1;

    // Wide carry chain and signed overflow
    drive8(1, 1, 8'hFF, 8'h00, 8'h00, 1, 0);
    drive8(1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 0);
    drive8(1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    drive8(1, 0, 8'h7F, 8'h01, 8'h80, 0, 1);
    drive8(1, 0, 8'h80, 8'hFF, 8'h7F, 1, 1);
    drive8(1, 1, 8'h12, 8'h34, 8'h47, 0, 0);
    drive8(0, 1, 8'hAA, 8'hAA, 8'h00, 0, 0);
    @(posedge clk); @(negedge clk);
    check("u8_hold", 64'({ov8, co8, s8}), 64'({1'b0, 1'b0, 8'h47}));

    // Combinational instance
    check_comb(1, 1, 4'h7, 4'h8, 4'h0, 1);
    check_comb(0, 1, 4'h7, 4'h8, 4'h0, 1);
    check_comb(1, 0, 4'hF, 4'hF, 4'hE, 1);
    check_comb(1, 0, 4'h3, 4'h4, 4'h7, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("u1_queue_drained", 64'(exp1_q.size()), 64'(0));
    check("u8_queue_drained", 64'(exp8_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder_implicit.md
Name: full_adder_implicit

Overview:
- Registered WIDTH-bit ripple full adder: {co, s} = a + b + ci.
- Sum is expressed arithmetically (implicit adder), with a one-cycle output register and valid tracking.
- Used as the leaf arithmetic cell in datapath blocks.
- With WIDTH=1 it is a classic single-bit full adder.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational, valid passed through.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- ci  input  1  carry in.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- s  output  WIDTH  sum, low WIDTH bits of a+b+ci.
- co  output  1  carry out, bit WIDTH of a+b+ci.
- out_valid  output  1  s/co hold a valid result.

Behaviour:
- Arithmetic: compute full = a + b + ci at WIDTH+1 bits, zero-extending all operands.
  - s = full[WIDTH-1:0].
  - co = full[WIDTH].
  - No truncation before the add.
- REG_OUT=1:
  - On a clk rising edge with in_valid=1: s, co load the new result and out_valid <= 1.
  - On a clk rising edge with in_valid=0: s and co hold their previous values and out_valid <= 0.
  - Latency is exactly 1 cycle. Throughput is one result per cycle with back-to-back in_valid.
- REG_OUT=0:
  - s and co follow the inputs combinationally regardless of in_valid.
  - out_valid = in_valid.
  - clk and rst_n are unused.
- Reset (REG_OUT=1): rst_n low immediately forces s=0, co=0, out_valid=0, independent of clk.
  - Reset asserted mid-operation discards any pending result.
  - The first valid result after rst_n deasserts appears one cycle after the first sampled in_valid=1.
- Boundaries:
  - a = b = all-ones with ci=1 gives s = all-ones, co = 1.
  - All-zero inputs give s=0, co=0.
  - X on an input while in_valid=0 must not disturb the held outputs.
- No backpressure: the downstream stage must accept every out_valid pulse.

Optional Feature:
- Macro: FULL_ADDER_IMPLICIT_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow.
  - ovf = (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]).
  - ovf has the same registration, hold and reset (0) rules as s and co.
- When undefined: the ovf port and its logic are absent, and the port list is exactly as above.

Test Plan:
- Truth table, WIDTH=1, REG_OUT=1, in_valid=1. Apply (ci,a,b) in this order, 200 ns per step, and check each result one clock later:
  - 000 -> s=0, co=0.
  - 010 -> s=1, co=0.
  - 011 -> s=0, co=1.
  - 001 -> s=1, co=0.
  - 101 -> s=0, co=1.
  - 111 -> s=1, co=1.
  - 110 -> s=0, co=1.
  - 100 -> s=1, co=0.
- Reset: drive a=1, b=1, ci=1 and clock once. Then assert rst_n=0 between edges -> s=0, co=0, out_valid=0 immediately, with no clk edge required.
- Hold: register a result (a=1, b=0, ci=0 -> s=1), then drop in_valid and change inputs to 111 -> s=1, co=0 held, out_valid=0 next cycle.
- Wide carry chain, WIDTH=8: a=8'hFF, b=8'h00, ci=1 -> s=8'h00, co=1. Then a=8'hFF, b=8'hFF, ci=1 -> s=8'hFF, co=1.
- Combinational, REG_OUT=0, WIDTH=4: a=4'h7, b=4'h8, ci=1 -> s=4'h0, co=1 in the same cycle, and out_valid tracks in_valid.
- FULL_ADDER_IMPLICIT_OVF_EN defined, WIDTH=8:
  - a=8'h7F, b=8'h01, ci=0 -> s=8'h80, ovf=1, co=0.
  - a=8'h80, b=8'hFF, ci=0 -> s=8'h7F, ovf=1, co=1.
